// File: rtl/regfile_writeback.sv
// ---------------------------------------------------------------------------
// regfile_writeback
//
// Purpose:
//   Retires results from the execute stage onto regfile write port 3. This
//   block is the only driver of that port. ALU results are written the cycle
//   after acceptance. Loads park in a single-entry pending buffer until memory
//   returns read data. The data is then sign/zero-extended or merged (LWL/LWR)
//   with the old destination value and written one cycle later. While a load
//   is pending, execute is back-pressured and the pending destination is
//   exported to the hazard unit.
//
// Ports:
//   clk                  system clock, all state on the rising edge
//   reset_i              synchronous active-high reset
//   req_valid_i          retire request present
//   req_ready_o          request accepted this cycle when valid & ready
//   req_is_load_i        1: result comes from memory, 0: use req_data_i
//   req_load_op_i        0 LW, 1 LB, 2 LBU, 3 LH, 4 LHU, 5 LWL, 6 LWR, 7 LW
//   req_byte_off_i       effective address bits [1:0]
//   req_dest_i           destination register
//   req_data_i           ALU result for non-loads
//   req_old_data_i       current destination value, used by the LWL/LWR merge
//   mem_readdatavalid_i  memory read data valid, one pulse per load
//   mem_readdata_i       memory read word, little-endian byte lanes
//   addr_3_o             regfile write address
//   write_data_3_o       regfile write data
//   write_enable_o       regfile write strobe, one-cycle pulse per retired op
//   stall_o              req_valid_i & ~req_ready_o
//   busy_valid_o         a load is pending
//   busy_dest_o          destination of the pending load (0 when none)
// ---------------------------------------------------------------------------
module regfile_writeback #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  reset_i,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic                  req_is_load_i,
    input  logic [2:0]            req_load_op_i,
    input  logic [1:0]            req_byte_off_i,
    input  logic [ADDR_WIDTH-1:0] req_dest_i,
    input  logic [DATA_WIDTH-1:0] req_data_i,
    input  logic [DATA_WIDTH-1:0] req_old_data_i,
    input  logic                  mem_readdatavalid_i,
    input  logic [DATA_WIDTH-1:0] mem_readdata_i,
    output logic [ADDR_WIDTH-1:0] addr_3_o,
    output logic [DATA_WIDTH-1:0] write_data_3_o,
    output logic                  write_enable_o,
    output logic                  stall_o,
    output logic                  busy_valid_o,
    output logic [ADDR_WIDTH-1:0] busy_dest_o
);

    // Load operation encodings (op 7 and op 0 both behave as LW).
    localparam logic [2:0] OP_LW  = 3'd0;
    localparam logic [2:0] OP_LB  = 3'd1;
    localparam logic [2:0] OP_LBU = 3'd2;
    localparam logic [2:0] OP_LH  = 3'd3;
    localparam logic [2:0] OP_LHU = 3'd4;
    localparam logic [2:0] OP_LWL = 3'd5;
    localparam logic [2:0] OP_LWR = 3'd6;

    typedef enum logic {
        IDLE     = 1'b0,
        WAIT_MEM = 1'b1
    } state_t;

    // ---------------------------------------------------------------------
    // State
    // ---------------------------------------------------------------------
    state_t                state_q, state_d;
    logic [2:0]            op_q, op_d;
    logic [1:0]            off_q, off_d;
    logic [ADDR_WIDTH-1:0] dest_q, dest_d;
    logic [DATA_WIDTH-1:0] old_q, old_d;

    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic                  we_q, we_d;

    // ---------------------------------------------------------------------
    // Load data formatting
    // ---------------------------------------------------------------------
    logic [7:0]            mem_bytes [4];
    logic [7:0]            old_bytes [4];
    logic [7:0]            lwl_bytes [4];
    logic [7:0]            lwr_bytes [4];
    logic [DATA_WIDTH-1:0] lwl_word;
    logic [DATA_WIDTH-1:0] lwr_word;
    logic [1:0]            lwl_shift;     // byte shift for LWL, 3 - offset
    logic [7:0]            byte_sel;
    logic [15:0]           half_sel;
    logic [DATA_WIDTH-1:0] load_result;

    assign lwl_shift = 2'd3 - off_q;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            localparam logic [1:0] LANE = 2'(gi);

            assign mem_bytes[gi] = mem_readdata_i[8*gi +: 8];
            assign old_bytes[gi] = old_q[8*gi +: 8];

            // LWL: memory shifted up by (3-off) bytes; lanes below the shift
            // keep the old register contents.
            assign lwl_bytes[gi] = (LANE >= lwl_shift) ? mem_bytes[LANE - lwl_shift]
                                                       : old_bytes[gi];

            // LWR: memory shifted down by off bytes; lanes above (3-off)
            // keep the old register contents.
            assign lwr_bytes[gi] = (LANE <= lwl_shift) ? mem_bytes[LANE + off_q]
                                                       : old_bytes[gi];

            assign lwl_word[8*gi +: 8] = lwl_bytes[gi];
            assign lwr_word[8*gi +: 8] = lwr_bytes[gi];
        end
    endgenerate

    assign byte_sel = mem_bytes[off_q];
    // Halfword loads use only offset bit 1; bit 0 is ignored.
    assign half_sel = off_q[1] ? mem_readdata_i[31:16] : mem_readdata_i[15:0];

    always_comb begin
        load_result = mem_readdata_i;
        case (op_q)
            OP_LB:   load_result = {{24{byte_sel[7]}}, byte_sel};
            OP_LBU:  load_result = {24'd0, byte_sel};
            OP_LH:   load_result = {{16{half_sel[15]}}, half_sel};
            OP_LHU:  load_result = {16'd0, half_sel};
            OP_LWL:  load_result = lwl_word;
            OP_LWR:  load_result = lwr_word;
            OP_LW:   load_result = mem_readdata_i;
            default: load_result = mem_readdata_i;
        endcase
    end

    // ---------------------------------------------------------------------
    // FSM next state and write-port staging
    // ---------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        off_d   = off_q;
        dest_d  = dest_q;
        old_d   = old_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        we_d    = 1'b0;

        case (state_q)
            IDLE: begin
                // Read data arriving here has no owner and is dropped.
                if (req_valid_i) begin
                    if (req_is_load_i) begin
                        op_d    = req_load_op_i;
                        off_d   = req_byte_off_i;
                        dest_d  = req_dest_i;
                        old_d   = req_old_data_i;
                        state_d = WAIT_MEM;
                    end else if (req_dest_i != '0) begin
                        addr_d  = req_dest_i;
                        wdata_d = req_data_i;
                        we_d    = 1'b1;
                    end
                end
            end
            WAIT_MEM: begin
                if (mem_readdatavalid_i) begin
                    // r0 loads still consume their data but never write.
                    if (dest_q != '0) begin
                        addr_d  = dest_q;
                        wdata_d = load_result;
                        we_d    = 1'b1;
                    end
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset_i) begin
            state_q <= IDLE;
            op_q    <= '0;
            off_q   <= '0;
            dest_q  <= '0;
            old_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            we_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            off_q   <= off_d;
            dest_q  <= dest_d;
            old_q   <= old_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            we_q    <= we_d;
        end
    end

    // ---------------------------------------------------------------------
    // Outputs
    // ---------------------------------------------------------------------
    // Ready is gated by reset so nothing is accepted while reset is held.
    assign req_ready_o    = (state_q == IDLE) && !reset_i;
    assign stall_o        = req_valid_i && !req_ready_o;
    assign busy_valid_o   = (state_q == WAIT_MEM);
    assign busy_dest_o    = (state_q == WAIT_MEM) ? dest_q : '0;

    assign addr_3_o       = addr_q;
    assign write_data_3_o = wdata_q;
    assign write_enable_o = we_q;

endmodule
